// File: rtl/fp_sched_pkg.sv
// Shared types for the FP adder scheduler: rounding-mode encodings, response record, word width.
package fp_sched_pkg;

  localparam int FP_W     = 32;
  localparam int ID_MAX_W = 3;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rnd_mode_e;

  // id is sized for the largest supported requester count and narrowed at the output
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [FP_W-1:0]     result;
    logic                overflow;
    logic                underflow;
  } fp_rsp_t;

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, pointer moves past the winner.
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;
  int              s;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    s       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = ID_W'(s);
      if (en && !gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_id == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                              ptr_d = gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one FP adder among NUM_REQ requesters with credit-based issue and an in-order response FIFO.
// Optional per-requester grant counters are built when FP_SCHED_PERF_EN is defined.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_fp_a,
  input  logic [NUM_REQ*FP_W-1:0] req_fp_b,
  input  logic [NUM_REQ*3-1:0]    req_r_mode,
  output logic                    add_valid,
  output logic [FP_W-1:0]         add_fp_a,
  output logic [FP_W-1:0]         add_fp_b,
  output logic [2:0]              add_r_mode,
  input  logic [FP_W-1:0]         add_fp_result,
  input  logic                    add_overflow,
  input  logic                    add_underflow,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_result,
  output logic                    rsp_overflow,
  output logic                    rsp_underflow,
  output logic [NUM_REQ*16-1:0]   perf_grant_cnt
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               can_issue, push, pop;
  logic [CNT_W-1:0]   out_q, out_d;

  // A credit is held from grant until the response leaves the FIFO, so a push can never find it full
  assign pop       = rsp_valid & rsp_ready;
  assign can_issue = (out_q < CNT_W'(RSP_DEPTH)) || ((out_q == CNT_W'(RSP_DEPTH)) && pop);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (can_issue & ~rst),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  logic [FP_W-1:0] sel_a, sel_b;
  rnd_mode_e       sel_r;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_r = RM_RNE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_fp_a[i*FP_W +: FP_W];
        sel_b = req_fp_b[i*FP_W +: FP_W];
        sel_r = rnd_mode_e'(req_r_mode[i*3 +: 3]);
      end
    end
  end

  // Issue register: operands to the adder
  logic            add_valid_q;
  logic [ID_W-1:0] iss_id_q;
  logic [FP_W-1:0] add_fp_a_q, add_fp_b_q;
  rnd_mode_e       add_r_mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid_q  <= 1'b0;
      iss_id_q     <= '0;
      add_fp_a_q   <= '0;
      add_fp_b_q   <= '0;
      add_r_mode_q <= RM_RNE;
    end else begin
      add_valid_q <= gnt_any;
      if (gnt_any) begin
        iss_id_q     <= gnt_id;
        add_fp_a_q   <= sel_a;
        add_fp_b_q   <= sel_b;
        add_r_mode_q <= sel_r;
      end
    end
  end

  assign add_valid  = add_valid_q;
  assign add_fp_a   = add_fp_a_q;
  assign add_fp_b   = add_fp_b_q;
  assign add_r_mode = add_r_mode_q;

  // Tag pipeline: stage LAT lines up with add_fp_result
  logic [LAT:1]    tag_vld_q;
  logic [ID_W-1:0] tag_id_q [1:LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[1] <= add_valid_q;
      for (int k = 2; k <= LAT; k++) tag_vld_q[k] <= tag_vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[1] <= iss_id_q;
    for (int k = 2; k <= LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
  end

  // Response FIFO
  fp_rsp_t          mem_q [RSP_DEPTH];
  fp_rsp_t          push_rsp, head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  assign push = tag_vld_q[LAT];

  always_comb begin
    push_rsp           = '0;
    push_rsp.id        = ID_MAX_W'(tag_id_q[LAT]);
    push_rsp.result    = add_fp_result;
    push_rsp.overflow  = add_overflow;
    push_rsp.underflow = add_underflow;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rsp;
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    out_d = out_q;
    if (gnt_any && !pop)      out_d = out_q + CNT_W'(1);
    else if (!gnt_any && pop) out_d = out_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_d;
      out_q      <= out_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rsp_valid     = (fifo_cnt_q != '0);
  assign rsp_id        = rsp_valid ? head.id[ID_W-1:0] : '0;
  assign rsp_result    = rsp_valid ? head.result       : '0;
  assign rsp_overflow  = rsp_valid & head.overflow;
  assign rsp_underflow = rsp_valid & head.underflow;

  logic unused_id_hi;
  assign unused_id_hi = ^head.id;

`ifdef FP_SCHED_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] perf_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i]) perf_q[i] <= sat_inc16(perf_q[i]);
    end
  end

  always_comb begin
    perf_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_grant_cnt[i*16 +: 16] = perf_q[i];
  end
`else
  assign perf_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a behavioural adder stub and a response scoreboard.
module tb_fp_add_scheduler;
  import fp_sched_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int LAT       = 2;
  localparam int RSP_DEPTH = 4;
  localparam int ID_W      = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_fp_a, req_fp_b;
  logic [NUM_REQ*3-1:0]    req_r_mode;
  logic                    add_valid;
  logic [31:0]             add_fp_a, add_fp_b;
  logic [2:0]              add_r_mode;
  logic [31:0]             add_fp_result;
  logic                    add_overflow, add_underflow;
  logic                    rsp_valid, rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [31:0]             rsp_result;
  logic                    rsp_overflow, rsp_underflow;
  logic [NUM_REQ*16-1:0]   perf_grant_cnt;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NUM_REQ(NUM_REQ), .LAT(LAT), .RSP_DEPTH(RSP_DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fp_a(req_fp_a), .req_fp_b(req_fp_b), .req_r_mode(req_r_mode),
    .add_valid(add_valid), .add_fp_a(add_fp_a), .add_fp_b(add_fp_b), .add_r_mode(add_r_mode),
    .add_fp_result(add_fp_result), .add_overflow(add_overflow), .add_underflow(add_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .perf_grant_cnt(perf_grant_cnt)
  );

  // Adder stub: exact doubling when both operands match, otherwise a scramble that depends on r_mode
  function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    if (a == b) begin
      if (a[30:23] == 8'h00) return {a[31], a[29:0], 1'b0};
      return {a[31], a[30:23] + 8'd1, a[22:0]};
    end
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, r};
  endfunction

  function automatic logic stub_ov(input logic [31:0] a, input logic [31:0] b);
    return a[0] ^ b[1];
  endfunction

  function automatic logic stub_un(input logic [31:0] a, input logic [31:0] b);
    return a[1] ^ b[0];
  endfunction

  logic [31:0] pa [1:LAT];
  logic [31:0] pb [1:LAT];
  logic [2:0]  pr [1:LAT];

  always @(posedge clk) begin
    pa[1] <= add_fp_a;
    pb[1] <= add_fp_b;
    pr[1] <= add_r_mode;
    for (int k = 2; k <= LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
      pr[k] <= pr[k-1];
    end
  end

  always_comb begin
    add_fp_result = stub_res(pa[LAT], pb[LAT], pr[LAT]);
    add_overflow  = stub_ov(pa[LAT], pb[LAT]);
    add_underflow = stub_un(pa[LAT], pb[LAT]);
  end

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    logic            ov;
    logic            un;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_grant  = 0;
  int   n_rsp    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
    req_fp_a[i*32 +: 32]  = a;
    req_fp_b[i*32 +: 32]  = b;
    req_r_mode[i*3 +: 3]  = r;
  endtask

  task automatic wait_rsp(input int max);
    for (int k = 0; k < max && !rsp_valid; k++) tick();
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_drain(input int max);
    for (int k = 0; k < max && sb.size() != 0; k++) tick();
    chk("drain_timeout", sb.size(), 0);
  endtask

  // Grant and response monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != '0) begin
        chk("gnt_onehot", $onehot(req_ready), 1);
        chk("gnt_subset", req_ready & ~req_valid, 0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id  = ID_W'(i);
          e.res = stub_res(req_fp_a[i*32 +: 32], req_fp_b[i*32 +: 32], req_r_mode[i*3 +: 3]);
          e.ov  = stub_ov(req_fp_a[i*32 +: 32], req_fp_b[i*32 +: 32]);
          e.un  = stub_un(req_fp_a[i*32 +: 32], req_fp_b[i*32 +: 32]);
          sb.push_back(e);
          n_grant++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_overflow", rsp_overflow, e.ov);
          chk("rsp_underflow", rsp_underflow, e.un);
        end
      end
      assert (int'(dut.fifo_cnt_q) <= RSP_DEPTH)
      else begin
        n_checks++;
        $error("FAIL fifo_overflow observed=%0d expected<=%0d", dut.fifo_cnt_q, RSP_DEPTH);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_perf;
    int g0, r0;

    // Reset state, with requests pending to prove grants are suppressed
    rst = 1'b1; req_valid = '1; req_fp_a = '0; req_fp_b = '0; req_r_mode = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_fp_a", add_fp_a, 0);
    chk("rst_add_r_mode", add_r_mode, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_perf", perf_grant_cnt, 0);
    req_valid = '0; rst = 1'b0; sb.delete();

    // Single request from requester 0: 1.0 + 1.0
    set_req(0, 32'h3F800000, 32'h3F800000, 3'b000);
    req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("single_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("single_add_valid", add_valid, 1);
    chk("single_add_fp_a", add_fp_a, 32'h3F800000);
    chk("single_add_fp_b", add_fp_b, 32'h3F800000);
    chk("single_add_r_mode", add_r_mode, 3'b000);
    for (int k = 0; k < LAT; k++) begin
      tick();
      chk("single_rsp_early", rsp_valid, 0);
      if (k == 0) chk("single_add_valid_drop", add_valid, 0);
    end
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_rsp_result", rsp_result, 32'h40000000);
    chk("single_rsp_flags", {rsp_overflow, rsp_underflow}, 2'b00);
    tick();

    // Subnormal passthrough from requester 2 with RTZ
    set_req(2, 32'h000A0000, 32'h000A0000, 3'b001);
    req_valid = 4'b0100;
    #1;
    chk("subn_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp(10);
    chk("subn_rsp_id", rsp_id, 2);
    chk("subn_rsp_result", rsp_result, 32'h00140000);
    wait_drain(20);

    // Reset with two ops in the tag pipeline and one in the FIFO
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    tick();
    chk("rstmid_fifo_occupied", rsp_valid, 1);
    chk("rstmid_outstanding", sb.size(), 3);
    rst = 1'b1; sb.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_rsp_cleared", rsp_valid, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("rstmid_no_stale", rsp_valid, 0);
    end

    // Round-robin with all requesters valid; pointer restarts at 0 after reset
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
    g0 = n_grant; r0 = n_rsp;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_order", req_ready, 64'(1) << (k % NUM_REQ));
      tick();
    end
    req_valid = '0;
    wait_drain(30);
    chk("rr_grants", n_grant - g0, 8);
    chk("rr_rsps", n_rsp - r0, 8);

    // Backpressure: exactly RSP_DEPTH grants, then held until the consumer drains
    for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
    g0 = n_grant; r0 = n_rsp;
    rsp_ready = 1'b0; req_valid = '1;
    repeat (12) tick();
    chk("bp_grants", n_grant - g0, RSP_DEPTH);
    chk("bp_ready_blocked", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_hold_id0", rsp_id, sb[0].id);
    chk("bp_hold_res0", rsp_result, sb[0].res);
    tick();
    chk("bp_hold_id1", rsp_id, sb[0].id);
    chk("bp_hold_res1", rsp_result, sb[0].res);
    chk("bp_still_blocked", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_resume", $onehot(req_ready), 1);
    tick();
    req_valid = '0;
    wait_drain(40);
    chk("bp_balance", n_rsp - r0, n_grant - g0);

    // Grant counters: 5 grants to requester 1, 3 to requester 3
    rst = 1'b1; sb.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("perf_after_rst", perf_grant_cnt, 0);
    g0 = n_grant;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    repeat (5) tick();
    req_valid = 4'b1000;
    repeat (3) tick();
    req_valid = '0;
    #1;
`ifdef FP_SCHED_PERF_EN
    exp_perf = {16'd3, 16'd0, 16'd5, 16'd0};
`else
    exp_perf = 64'd0;
`endif
    chk("perf_grants", n_grant - g0, 8);
    chk("perf_counts", perf_grant_cnt, exp_perf);
    wait_drain(30);

    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
